video_timing_engine: RTL and testbench
======================================

# video_timing_engine

Parametrised single-clock raster timing engine for the display path. It generates sync and display-enable for any VESA-style mode, with a configurable displayed-line window inside the active area. It drives a one-line-ahead scanline prefetch request/acknowledge handshake carrying a bank-relative VRAM address, and reports frame and vertical-blank events. It sits in the pixel clock domain between the system bank select and the line-buffer/prefetch logic.

## Interface
- H_ACTIVE, 1024, active pixels per line
- H_FRONT, 24, horizontal front porch (pixels)
- H_SYNC, 136, hsync pulse width (pixels)
- H_BACK, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, active lines
- V_FRONT, 3; V_SYNC, 6; V_BACK, 29, vertical porches and sync (lines)
- V_DISPLAY, 600, lines actually displayed; lines V_DISPLAY..V_ACTIVE-1 are blanked; 1 ≤ V_DISPLAY ≤ V_ACTIVE
- H_SYNC_POL, 0; V_SYNC_POL, 0, active sync level (0 = negative)
- ADDR_W, 20, VRAM address width
- BANK_BITS, 1, bank select width; the bank occupies the address MSBs
- LINE_STRIDE, 512, address increment per line
- Derived: H_TOTAL = sum of H_*, V_TOTAL = sum of V_*, HW = $clog2(H_TOTAL), VW = $clog2(V_TOTAL)

Ports:
- i_pixel_clk, in, 1, the only clock
- i_reset, in, 1, asynchronous, active-high reset
- i_enable, in, 1, when low, counters and the prefetch state freeze
- i_bank, in, BANK_BITS, frame bank select; sampled only at the line-0 prefetch
- o_hsync, o_vsync, out, 1, syncs at the configured polarity
- o_de, out, 1, pixel displayed
- o_x, out, HW, horizontal position of the current pixel
- o_y, out, VW, vertical position of the current pixel
- o_frame_start, out, 1, one-cycle pulse
- o_vblank_start, out, 1, one-cycle pulse; bank switching is allowed from this point
- o_prefetch_req, out, 1, line fetch request
- o_prefetch_addr, out, ADDR_W, start address of the requested line
- i_prefetch_ack, in, 1, request accepted
- o_prefetch_overrun, out, 1, one-cycle pulse

## Operation
- **Counters.** Internal h counts 0..H_TOTAL-1 and wraps; v advances when h wraps and counts 0..V_TOTAL-1, then wraps.
- **Line layout.** Active region first: h < H_ACTIVE is active, then front porch, sync, back porch. The same ordering applies to v.
- **Syncs.**
  - hsync is active for H_ACTIVE+H_FRONT ≤ h < H_ACTIVE+H_FRONT+H_SYNC.
  - vsync is active for V_ACTIVE+V_FRONT ≤ v < V_ACTIVE+V_FRONT+V_SYNC, over whole lines.
- **Display enable.** de = (h < H_ACTIVE) && (v < V_DISPLAY).
- **Event pulses.**
  - o_frame_start asserts at h=0, v=0.
  - o_vblank_start asserts at h=0, v=V_DISPLAY.
- **Prefetch trigger.** At h == H_ACTIVE, compute next line n = (v == V_TOTAL-1) ? 0 : v+1. If n < V_DISPLAY, raise a request for line n.
  - For n = 0: latch i_bank into the bank register, and set addr = bank << (ADDR_W-BANK_BITS).
  - Otherwise: addr = previous addr + LINE_STRIDE. No multiplier is used.
- **Handshake.**
  - o_prefetch_req holds high, with o_prefetch_addr stable, until i_prefetch_ack is sampled high.
  - o_prefetch_req drops on the cycle after the ack is sampled.
  - Ack while req is low is ignored.
- **Overrun.** If a new trigger fires while req is still high:
  - o_prefetch_overrun pulses for one cycle.
  - The stale request is replaced by the new line's address.
  - req stays high.
  - The address chain still advances, so line addresses stay correct.
- **Simultaneous events.** If a trigger and an ack occur in the same cycle, the ack retires the old request. The new request is raised, and no overrun is reported.
- **Enable low.** h, v, req, addr and bank hold their values. o_frame_start, o_vblank_start and o_prefetch_overrun are forced to 0. Other outputs hold. Acks are still accepted.
- **Address range.** Address arithmetic wraps modulo 2^ADDR_W. The configuration must guarantee V_DISPLAY*LINE_STRIDE ≤ 2^(ADDR_W-BANK_BITS).

## Timing
- **Output registration.** All outputs are registered. o_x, o_y, o_de, the syncs and the event pulses at cycle t+1 describe counter state (h, v) at cycle t. They are mutually aligned.
- **Request latency.** o_prefetch_req rises one cycle after the counter state h == H_ACTIVE.
- **Reset values (asynchronous).**
  - h = 0, v = 0; o_x = 0, o_y = 0.
  - o_hsync = !H_SYNC_POL, o_vsync = !V_SYNC_POL.
  - o_de = 0, all pulses 0, o_prefetch_req = 0, o_prefetch_addr = 0, bank register = 0.
  - The first post-reset output cycle shows (0,0) with o_frame_start = 1 and o_de = 1.
- **Reset mid-request.** Reset clears req immediately. No overrun is reported.
- **Request lead time.** Each line's request is issued H_TOTAL-H_ACTIVE cycles (320 at defaults) before that line's first displayed pixel.

## Test plan
- **Sync timing.** Defaults, 2 frames:
  - o_hsync low for exactly 136 cycles, starting at o_x = 1048.
  - o_vsync low for lines 771..776.
  - Period 1344×806 cycles.
- **Display window.** Over one frame, o_de count = 614400. o_de = 0 on every line with o_y ≥ 600.
- **Prefetch addresses.** Ack 3 cycles after each request, i_bank = 1:
  - Request at v=805, h=1024 with addr 0x80000.
  - Line 599 request addr = 0x80000 + 599·512 = 0xCAE00.
  - No request at v=599.
- **Bank sampling.** Toggle i_bank at v=300: addresses for the current frame keep the old bank. The next frame's line 0 request uses the new bank.
- **Overrun.** Never ack:
  - o_prefetch_overrun pulses once per displayed-line trigger after the first.
  - o_prefetch_addr tracks the newest line.
  - Ack in the same cycle as a trigger produces no overrun.
- **Enable and reset.**
  - Drop i_enable for 100 cycles mid-line: o_x freezes and resumes without skipping a value.
  - Assert i_reset mid-request: o_prefetch_req falls asynchronously, and all outputs take their reset values.

Source files
------------

// File: rtl/video_timing_engine.sv
// Raster timing engine: sync/DE generation, displayed-line window, frame/vblank events,
// and a one-line-ahead scanline prefetch request/ack handshake with bank-relative addressing.
module video_timing_engine #(
  parameter int H_ACTIVE    = 1024,
  parameter int H_FRONT     = 24,
  parameter int H_SYNC      = 136,
  parameter int H_BACK      = 160,
  parameter int V_ACTIVE    = 768,
  parameter int V_FRONT     = 3,
  parameter int V_SYNC      = 6,
  parameter int V_BACK      = 29,
  parameter int V_DISPLAY   = 600,
  parameter bit H_SYNC_POL  = 1'b0,
  parameter bit V_SYNC_POL  = 1'b0,
  parameter int ADDR_W      = 20,
  parameter int BANK_BITS   = 1,
  parameter int LINE_STRIDE = 512,
  localparam int H_TOTAL    = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL    = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int HW         = $clog2(H_TOTAL),
  localparam int VW         = $clog2(V_TOTAL)
) (
  input  logic                 i_pixel_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [BANK_BITS-1:0] i_bank,
  output logic                 o_hsync,
  output logic                 o_vsync,
  output logic                 o_de,
  output logic [HW-1:0]        o_x,
  output logic [VW-1:0]        o_y,
  output logic                 o_frame_start,
  output logic                 o_vblank_start,
  output logic                 o_prefetch_req,
  output logic [ADDR_W-1:0]    o_prefetch_addr,
  input  logic                 i_prefetch_ack,
  output logic                 o_prefetch_overrun
);

  localparam int OFF_W = ADDR_W - BANK_BITS;

  logic [HW-1:0]        h;
  logic [VW-1:0]        v;
  logic [VW-1:0]        next_line;
  logic                 h_last;
  logic                 v_last;
  logic                 hs_active;
  logic                 vs_active;
  logic                 trigger;
  logic [BANK_BITS-1:0] bank_q;
  logic [OFF_W-1:0]     offset_q;

  always_comb begin
    h_last    = (h == HW'(H_TOTAL - 1));
    v_last    = (v == VW'(V_TOTAL - 1));
    next_line = v_last ? '0 : v + VW'(1);
    hs_active = (int'(h) >= H_ACTIVE + H_FRONT) && (int'(h) < H_ACTIVE + H_FRONT + H_SYNC);
    vs_active = (int'(v) >= V_ACTIVE + V_FRONT) && (int'(v) < V_ACTIVE + V_FRONT + V_SYNC);
    trigger   = i_enable && (h == HW'(H_ACTIVE)) && (next_line < VW'(V_DISPLAY));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_pixel_clk or posedge i_reset) begin
    if (i_reset) begin
      h <= '0;
      v <= '0;
    end else if (i_enable) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + VW'(1);
      end else begin
        h <= h + HW'(1);
      end
    end
  end

  // Outputs describe the counter state of the previous cycle; all fields share that delay.
  always_ff @(posedge i_pixel_clk or posedge i_reset) begin
    if (i_reset) begin
      o_x            <= '0;
      o_y            <= '0;
      o_de           <= 1'b0;
      o_hsync        <= !H_SYNC_POL;
      o_vsync        <= !V_SYNC_POL;
      o_frame_start  <= 1'b0;
      o_vblank_start <= 1'b0;
    end else if (i_enable) begin
      o_x            <= h;
      o_y            <= v;
      o_de           <= (int'(h) < H_ACTIVE) && (int'(v) < V_DISPLAY);
      o_hsync        <= hs_active ? H_SYNC_POL : !H_SYNC_POL;
      o_vsync        <= vs_active ? V_SYNC_POL : !V_SYNC_POL;
      o_frame_start  <= (h == '0) && (v == '0);
      o_vblank_start <= (h == '0) && (v == VW'(V_DISPLAY));
    end else begin
      o_frame_start  <= 1'b0;
      o_vblank_start <= 1'b0;
    end
  end

  // The bank sits in the address MSBs; the line offset chains by stride addition and never
  // carries into the bank field for a legal configuration, so the two can be kept apart.
  always_ff @(posedge i_pixel_clk or posedge i_reset) begin
    if (i_reset) begin
      o_prefetch_req     <= 1'b0;
      o_prefetch_overrun <= 1'b0;
      bank_q             <= '0;
      offset_q           <= '0;
    end else begin
      o_prefetch_overrun <= trigger && o_prefetch_req && !i_prefetch_ack;
      if (trigger) begin
        o_prefetch_req <= 1'b1;
        if (next_line == '0) begin
          bank_q   <= i_bank;
          offset_q <= '0;
        end else begin
          offset_q <= offset_q + OFF_W'(LINE_STRIDE);
        end
      end else if (i_prefetch_ack) begin
        o_prefetch_req <= 1'b0;
      end
    end
  end

  assign o_prefetch_addr = {bank_q, offset_q};

endmodule

// File: tb/tb_video_timing_engine.sv
// Directed bench for video_timing_engine in a reduced mode (24x15 total, 16x10 active,
// 7 displayed lines) so several frames fit in a short run.
module tb_video_timing_engine;

  localparam int H_ACTIVE = 16, H_FRONT = 2, H_SYNC = 3, H_BACK = 3;
  localparam int V_ACTIVE = 10, V_FRONT = 1, V_SYNC = 2, V_BACK = 2;
  localparam int V_DISPLAY = 7;
  localparam bit H_SYNC_POL = 1'b0, V_SYNC_POL = 1'b1;
  localparam int ADDR_W = 12, BANK_BITS = 1, LINE_STRIDE = 64;
  localparam int H_TOTAL = 24, V_TOTAL = 15, FRAME = H_TOTAL * V_TOTAL;

  logic        clk = 1'b0;
  logic        i_reset, i_enable, i_prefetch_ack;
  logic [0:0]  i_bank;
  logic        o_hsync, o_vsync, o_de, o_frame_start, o_vblank_start;
  logic [4:0]  o_x;
  logic [3:0]  o_y;
  logic        o_prefetch_req, o_prefetch_overrun;
  logic [11:0] o_prefetch_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int ex = 0, ey = 0, de_cnt = 0;
  logic [11:0] base = '0;

  video_timing_engine #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .V_DISPLAY(V_DISPLAY), .H_SYNC_POL(H_SYNC_POL), .V_SYNC_POL(V_SYNC_POL),
    .ADDR_W(ADDR_W), .BANK_BITS(BANK_BITS), .LINE_STRIDE(LINE_STRIDE)
  ) dut (
    .i_pixel_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_bank(i_bank),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de), .o_x(o_x), .o_y(o_y),
    .o_frame_start(o_frame_start), .o_vblank_start(o_vblank_start),
    .o_prefetch_req(o_prefetch_req), .o_prefetch_addr(o_prefetch_addr),
    .i_prefetch_ack(i_prefetch_ack), .o_prefetch_overrun(o_prefetch_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (x=%0d y=%0d)", tag, got, exp, ex, ey);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One enabled cycle: check the raster outputs against the position (ex, ey) they must show,
  // optionally check the prefetch handshake with an ack issued on the third request cycle.
  task automatic step_check(input bit pf_chk);
    int  nl;
    logic exp_req;
    tick();
    nl = (ey == V_TOTAL - 1) ? 0 : ey + 1;
    if (ex == H_ACTIVE && nl == 0) base = {i_bank, 11'b0};
    check("x", 32'(o_x), ex);
    check("y", 32'(o_y), ey);
    check("de", 32'(o_de), 32'(ex < H_ACTIVE && ey < V_DISPLAY));
    check("hsync", 32'(o_hsync),
          32'((ex >= 18 && ex < 21) ? H_SYNC_POL : !H_SYNC_POL));
    check("vsync", 32'(o_vsync),
          32'((ey >= 11 && ey < 13) ? V_SYNC_POL : !V_SYNC_POL));
    check("frame_start", 32'(o_frame_start), 32'(ex == 0 && ey == 0));
    check("vblank_start", 32'(o_vblank_start), 32'(ex == 0 && ey == V_DISPLAY));
    if (pf_chk) begin
      exp_req = (ex >= 16 && ex <= 18 && nl < V_DISPLAY);
      check("req", 32'(o_prefetch_req), 32'(exp_req));
      if (exp_req) check("addr", 32'(o_prefetch_addr), 32'(base) + nl * LINE_STRIDE);
      check("overrun", 32'(o_prefetch_overrun), 0);
      i_prefetch_ack = (ex == H_ACTIVE + 2);
    end
    de_cnt += int'(o_de);
    if (ex == H_TOTAL - 1 && ey == V_TOTAL - 1) begin
      check("de_count", de_cnt, H_ACTIVE * V_DISPLAY);
      de_cnt = 0;
    end
    if (ex == H_TOTAL - 1) begin
      ex = 0;
      ey = (ey == V_TOTAL - 1) ? 0 : ey + 1;
    end else begin
      ex++;
    end
  endtask

  task automatic run_to_trigger();
    while (ex != H_ACTIVE) step_check(1'b0);
  endtask

  initial begin
    i_reset = 1'b1;
    i_enable = 1'b1;
    i_bank = 1'b1;
    i_prefetch_ack = 1'b0;
    repeat (3) tick();
    check("rst_x", 32'(o_x), 0);
    check("rst_y", 32'(o_y), 0);
    check("rst_hsync", 32'(o_hsync), 1);
    check("rst_vsync", 32'(o_vsync), 0);
    check("rst_de", 32'(o_de), 0);
    check("rst_fs", 32'(o_frame_start), 0);
    check("rst_req", 32'(o_prefetch_req), 0);
    check("rst_addr", 32'(o_prefetch_addr), 0);
    i_reset = 1'b0;

    // Three frames with auto-ack; bank flips mid frame 1 and only frame 2 sees it.
    for (int c = 0; c < 3 * FRAME; c++) begin
      step_check(1'b1);
      if (c == FRAME + 3 * H_TOTAL) i_bank = 1'b0;
    end

    // Freeze with a request pending; the ack is accepted while frozen.
    repeat (17) step_check(1'b0);
    check("pend_req", 32'(o_prefetch_req), 1);
    check("pend_addr", 32'(o_prefetch_addr), 12'h040);
    i_enable = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("frz_x", 32'(o_x), 16);
      check("frz_y", 32'(o_y), 0);
      check("frz_req", 32'(o_prefetch_req), 32'(i <= 9));
      check("frz_fs", 32'(o_frame_start), 0);
      i_prefetch_ack = (i == 9);
    end
    i_enable = 1'b1;
    step_check(1'b0);
    check("resume_req", 32'(o_prefetch_req), 0);

    // Never ack: overruns replace the pending request.
    run_to_trigger();
    step_check(1'b0);
    check("ov1_req", 32'(o_prefetch_req), 1);
    check("ov1_addr", 32'(o_prefetch_addr), 12'h080);
    check("ov1_ovr", 32'(o_prefetch_overrun), 0);
    run_to_trigger();
    step_check(1'b0);
    check("ov2_req", 32'(o_prefetch_req), 1);
    check("ov2_addr", 32'(o_prefetch_addr), 12'h0C0);
    check("ov2_ovr", 32'(o_prefetch_overrun), 1);
    step_check(1'b0);
    check("ov2_pulse_end", 32'(o_prefetch_overrun), 0);
    run_to_trigger();
    step_check(1'b0);
    check("ov3_addr", 32'(o_prefetch_addr), 12'h100);
    check("ov3_ovr", 32'(o_prefetch_overrun), 1);

    // Ack coincident with a trigger: old request retires, new one raised, no overrun.
    run_to_trigger();
    i_prefetch_ack = 1'b1;
    step_check(1'b0);
    i_prefetch_ack = 1'b0;
    check("sim_req", 32'(o_prefetch_req), 1);
    check("sim_addr", 32'(o_prefetch_addr), 12'h140);
    check("sim_ovr", 32'(o_prefetch_overrun), 0);
    step_check(1'b0);
    check("sim_req_hold", 32'(o_prefetch_req), 1);

    // Asynchronous reset while a request is pending.
    #2;
    i_reset = 1'b1;
    #1;
    check("arst_req", 32'(o_prefetch_req), 0);
    check("arst_x", 32'(o_x), 0);
    check("arst_y", 32'(o_y), 0);
    check("arst_hsync", 32'(o_hsync), 1);
    check("arst_vsync", 32'(o_vsync), 0);
    check("arst_de", 32'(o_de), 0);
    check("arst_addr", 32'(o_prefetch_addr), 0);
    check("arst_ovr", 32'(o_prefetch_overrun), 0);
    repeat (2) tick();
    i_reset = 1'b0;
    tick();
    check("post_x", 32'(o_x), 0);
    check("post_y", 32'(o_y), 0);
    check("post_fs", 32'(o_frame_start), 1);
    check("post_de", 32'(o_de), 1);
    check("post_req", 32'(o_prefetch_req), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
